// File: rtl/cbus_ram_responder.sv
// cbus_ram_responder: memory-side responder for the cache bus.
// Accepts one burst request at a time and serves it from an internal
// word-addressed RAM. Read beats return the addressed word combinationally.
// Write beats commit the strobed byte lanes on each ready cycle.
// Optional feature macro: CBUS_RESP_CHECK_EN adds a sticky protocol checker
// that drives proto_err. When the macro is undefined, proto_err is tied to 0.

package cbus_pkg;
   localparam logic [2:0] MSIZE1 = 3'd0;
   localparam logic [2:0] MSIZE2 = 3'd1;
   localparam logic [2:0] MSIZE4 = 3'd2;

   localparam logic [3:0] MLEN1  = 4'd0;
   localparam logic [3:0] MLEN2  = 4'd1;
   localparam logic [3:0] MLEN4  = 4'd3;
   localparam logic [3:0] MLEN8  = 4'd7;
   localparam logic [3:0] MLEN16 = 4'd15;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [3:0]  len;      // beats - 1
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

module cbus_ram_responder
   import cbus_pkg::*;
#(
   parameter int MEM_WORDS = 4096,
   parameter int FIRST_LAT = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  cbus_req_t  creq,
   output cbus_resp_t cresp,
   output logic       proto_err
);

   localparam int AW = $clog2(MEM_WORDS);

   // Handshake: a request is accepted in IDLE when creq.valid is high. The
   // initiator keeps valid, addr, len and is_write steady until the beat
   // flagged last. Each cycle with cresp.ready high is one beat: read data is
   // valid during that cycle, and write data/strobe are committed at its end.
   // Dropping valid in WAIT or BURST aborts the burst.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            wr_q, wr_d;
   logic [3:0]      len_q, len_d;
   logic [AW-1:0]   base_q, base_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      lat_q, lat_d;

   logic [31:0]     mem [MEM_WORDS];
   logic [AW-1:0]   beat_idx;
   logic            beat_we;
   logic            is_last;

   // The beat index wraps modulo the RAM depth, because the RAM depth is a
   // power of two.
   assign beat_idx = base_q + AW'(cnt_q);
   assign is_last  = (cnt_q == len_q);

   // State and burst bookkeeping registers. The RAM is deliberately not reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         len_q   <= '0;
         base_q  <= '0;
         cnt_q   <= '0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         len_q   <= len_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
      end
   end

   // Next-state logic and response outputs. cresp is derived from the state
   // register, so an asynchronous reset clears it immediately.
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      len_d   = len_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      cresp   = '0;
      beat_we = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (creq.valid) begin
               wr_d   = creq.is_write;
               len_d  = creq.len;
               base_d = creq.addr[2 +: AW];
               cnt_d  = '0;
               if (FIRST_LAT == 0) begin
                  state_d = S_BURST;
                  lat_d   = '0;
               end else begin
                  state_d = S_WAIT;
                  lat_d   = 4'(FIRST_LAT);
               end
            end
         end
         S_WAIT: begin
            if (!creq.valid) begin
               state_d = S_IDLE;
               lat_d   = '0;
            end else if (lat_q <= 4'd1) begin
               state_d = S_BURST;
               lat_d   = '0;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         S_BURST: begin
            cresp.ready = 1'b1;
            cresp.last  = is_last;
            cresp.data  = wr_q ? 32'h0 : mem[beat_idx];
            if (!creq.valid) begin
               state_d = S_IDLE;
            end else begin
               beat_we = wr_q;
               if (is_last) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Write the strobed byte lanes of the current beat into the RAM.
   always_ff @(posedge clk) begin
      if (beat_we) begin
         for (int i = 0; i < 4; i++) begin
            if (creq.strobe[i]) begin
               mem[beat_idx][8*i +: 8] <= creq.data[8*i +: 8];
            end
         end
      end
   end

`ifdef CBUS_RESP_CHECK_EN
   logic [31:0] addr_q;
   logic        err_q;
   logic        viol;

   // Keep the full request address so that any change during the burst is
   // caught, including changes to bits that do not select the word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q <= '0;
      end else if (state_q == S_IDLE && creq.valid) begin
         addr_q <= creq.addr;
      end
   end

   // Detect protocol violations. Dropping valid in WAIT or BURST always comes
   // before the last beat, because the last beat returns the block to IDLE.
   always_comb begin
      viol = 1'b0;
      if (state_q == S_IDLE) begin
         viol = creq.valid && (creq.size < MSIZE4) && (creq.len != 4'd0);
      end else begin
         viol = !creq.valid || (creq.addr != addr_q) ||
                (creq.len != len_q) || (creq.is_write != wr_q);
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | viol;
      end
   end

   assign proto_err = err_q;
`else
   logic unused_req_bits;
   assign unused_req_bits = ^{creq.size, creq.addr[1:0], creq.addr[31:AW+2]};
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Testbench for cbus_ram_responder.
// The driver issues bursts and pushes the expected beats, as {last, data}, into
// exp_q. A negedge monitor pops exp_q and compares it with each ready beat.
// The reference RAM model is a plain word array. It is updated when a write
// beat commits.
module tb_cbus_ram_responder;
   import cbus_pkg::*;

   localparam int MEM_WORDS = 4096;
   localparam int FIRST_LAT = 2;
   localparam int AW        = 12;

   logic       clk = 1'b0;
   logic       resetn;
   cbus_req_t  creq;
   cbus_resp_t cresp;
   logic       proto_err;

   logic [31:0] model_mem [MEM_WORDS];
   logic [32:0] exp_q [$];
   logic [31:0] wdata_tab [16];
   logic [3:0]  wstrb_tab [16];
   int          checks   = 0;
   int          failures = 0;
   logic        mon_en   = 1'b1;
   logic        exp_perr;

   // clock / reset
   always #5 clk = ~clk;

   cbus_ram_responder #(.MEM_WORDS(MEM_WORDS), .FIRST_LAT(FIRST_LAT)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .creq      (creq),
      .cresp     (cresp),
      .proto_err (proto_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
      for (int i = 0; i < 4; i++)
         if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (mon_en && resetn && cresp.ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(cresp), 64'h0);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("beat", 64'({cresp.last, cresp.data}), 64'(e));
         end
      end
   end

   // Issues one burst. Pass abort_after >= 0 to drop valid after that many
   // beats. Pass reset_after >= 0 to pull resetn low after that many beats.
   task automatic do_burst(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input int abort_after, input int reset_after);
      int nexp;
      int base;
      int n;
      base = int'(addr[2 +: AW]);
      nexp = int'(len) + 1;
      if (abort_after >= 0) nexp = abort_after;
      if (reset_after >= 0) nexp = reset_after;
      for (int i = 0; i < nexp; i++)
         exp_q.push_back({(i == int'(len)), wr ? 32'h0 : model_mem[(base + i) % MEM_WORDS]});
      creq.valid    = 1'b1;
      creq.is_write = wr;
      creq.size     = size;
      creq.addr     = addr;
      creq.len      = len;
      creq.data     = wdata_tab[0];
      creq.strobe   = wstrb_tab[0];
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (cresp.ready || n > 40) break;
      end
      if (n > 40) begin
         check("ready_timeout", 64'(n), 64'(FIRST_LAT + 2));
         creq.valid = 1'b0;
         exp_q.delete();
         @(posedge clk); #1;
         return;
      end
      check("first_latency", 64'(n), 64'(FIRST_LAT + 2));
      for (int b = 0; b <= int'(len); b++) begin
         if (b > 0) check("ready_held", 64'(cresp.ready), 64'h1);
         @(posedge clk);
         if (wr) model_write((base + b) % MEM_WORDS, wdata_tab[b], wstrb_tab[b]);
         #1;
         if (b == int'(len)) begin
            creq.valid = 1'b0;
            break;
         end
         if (b + 1 == abort_after) begin
            creq.valid = 1'b0;
            mon_en = 1'b0;
            @(negedge clk);
            @(posedge clk); #1;
            mon_en = 1'b1;
            @(negedge clk);
            check("abort_idle_ready", 64'(cresp.ready), 64'h0);
            check("abort_proto_err", 64'(proto_err), 64'(exp_perr));
            @(posedge clk); #1;
            return;
         end
         if (b + 1 == reset_after) begin
            resetn = 1'b0;
            creq.valid = 1'b0;
            #1;
            check("reset_resp_zero", 64'(cresp), 64'h0);
            check("reset_proto_err", 64'(proto_err), 64'h0);
            check("reset_exp_drained", 64'(exp_q.size()), 64'h0);
            exp_q.delete();
            @(posedge clk); #1;
            resetn = 1'b1;
            @(posedge clk); #1;
            return;
         end
         creq.data   = wdata_tab[b + 1];
         creq.strobe = wstrb_tab[b + 1];
         @(negedge clk);
      end
   endtask

   task automatic fill_tab(input logic [31:0] first, input logic [3:0] strb);
      for (int i = 0; i < 16; i++) begin
         wdata_tab[i] = first + 32'(i);
         wstrb_tab[i] = strb;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef CBUS_RESP_CHECK_EN
      exp_perr = 1'b1;
`else
      exp_perr = 1'b0;
`endif
      resetn = 1'b0;
      creq   = '0;
      fill_tab(32'h0, 4'hF);
      repeat (3) @(posedge clk);
      #1;
      check("reset_cresp", 64'(cresp), 64'h0);
      check("reset_perr", 64'(proto_err), 64'h0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Preload word k = 0x1000_0000 + k.
      for (int blk = 0; blk < MEM_WORDS / 16; blk++) begin
         fill_tab(32'h1000_0000 + 32'(blk * 16), 4'hF);
         do_burst(1'b1, 32'(blk * 64), MLEN16, MSIZE4, -1, -1);
      end

      // 16-beat read at 0x40
      do_burst(1'b0, 32'h40, MLEN16, MSIZE4, -1, -1);

      // 4-beat write 0xA0..0xA3 at 0x100, then read back
      fill_tab(32'hA0, 4'hF);
      do_burst(1'b1, 32'h100, MLEN4, MSIZE4, -1, -1);
      do_burst(1'b0, 32'h100, MLEN4, MSIZE4, -1, -1);

      // byte-strobe merge on word 0x200
      fill_tab(32'h1122_3344, 4'hF);
      do_burst(1'b1, 32'h800, MLEN1, MSIZE4, -1, -1);
      wdata_tab[0] = 32'hFFFF_FFFF; wstrb_tab[0] = 4'b0101;
      do_burst(1'b1, 32'h800, MLEN1, MSIZE1, -1, -1);
      check("strobe_model", 64'(model_mem[32'h200]), 64'h11FF_33FF);
      do_burst(1'b0, 32'h800, MLEN1, MSIZE4, -1, -1);

      // wrap at the top of RAM
      do_burst(1'b0, 32'h3FF8, MLEN4, MSIZE4, -1, -1);

      // reset during a 16-beat write, then read the region back
      fill_tab(32'hB000_0000, 4'hF);
      do_burst(1'b1, 32'h2000, MLEN16, MSIZE4, -1, 5);
      do_burst(1'b0, 32'h2000, MLEN16, MSIZE4, -1, -1);

      // abort an 8-beat read after 3 beats
      do_burst(1'b0, 32'h400, MLEN8, MSIZE4, 3, -1);
      // abort an 8-beat write after 3 beats; later words must be unchanged
      fill_tab(32'hC000_0000, 4'hF);
      do_burst(1'b1, 32'h600, MLEN8, MSIZE4, 3, -1);
      do_burst(1'b0, 32'h600, MLEN8, MSIZE4, -1, -1);

      // randomized traffic
      for (int t = 0; t < 150; t++) begin
         logic [3:0]  len;
         logic [2:0]  size;
         logic [31:0] addr;
         logic        wr;
         wr   = 1'($urandom_range(0, 1));
         len  = 4'($urandom_range(0, 15));
         size = (len == 4'd0) ? 3'($urandom_range(0, 2)) : MSIZE4;
         addr = $urandom;
         for (int i = 0; i < 16; i++) begin
            wdata_tab[i] = $urandom;
            wstrb_tab[i] = 4'($urandom_range(0, 15));
         end
         do_burst(wr, addr, len, size, -1, -1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      check("exp_q_drained", 64'(exp_q.size()), 64'h0);
      check("sticky_proto_err", 64'(proto_err), 64'(exp_perr));
      resetn = 1'b0;
      #1;
      check("final_reset_perr", 64'(proto_err), 64'h0);
      check("final_reset_cresp", 64'(cresp), 64'h0);
      @(posedge clk); #1;
      resetn = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
